imem_load_arbiter: RTL

- Sits between the CPU fetch stage and a write-capable instruction memory: 32 x 32-bit words, asynchronous read, synchronous write.
- Normally passes CPU fetches straight through to the memory.
- While the external loader asserts load_en, it stalls the CPU and takes ownership of the memory port.
- In load mode it assembles a little-endian byte stream into 32-bit words and writes them to consecutive addresses starting at 0.
- This is how programs get into instruction memory without re-synthesis.

---
 rtl/imem_load_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: passes CPU fetches through to memory, or
// lets an external loader stream little-endian bytes into it while the CPU stalls.
module imem_load_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_valid,
    output logic              cpu_stall,
    input  logic              load_en,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FULL
    } state_t;

    state_t              state, state_next;
    logic [1:0]          byte_cnt, byte_cnt_next;
    logic [DATA_W-1:0]   word_buf, word_next;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_next;
    logic [ADDR_W:0]     count_next;
    logic                err_next;
    logic                done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_buf   <= '0;
            wr_ptr     <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_next;
            byte_cnt   <= byte_cnt_next;
            word_buf   <= word_next;
            wr_ptr     <= wr_ptr_next;
            load_count <= count_next;
            load_err   <= err_next;
            load_done  <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        word_next     = word_buf;
        wr_ptr_next   = wr_ptr;
        count_next    = load_count;
        err_next      = load_err;
        done_next     = 1'b0;

        mem_addr      = wr_ptr;
        mem_wdata     = word_buf;
        mem_we        = 1'b0;
        fetch_inst    = mem_rdata;
        fetch_valid   = 1'b0;
        cpu_stall     = 1'b1;
        ld_ready      = 1'b0;

        unique case (state)
            IDLE: begin
                mem_addr    = fetch_addr;
                fetch_valid = fetch_req;
                cpu_stall   = 1'b0;
                if (load_en) begin
                    state_next    = LOAD;
                    byte_cnt_next = '0;
                    wr_ptr_next   = '0;
                    count_next    = '0;
                    err_next      = 1'b0;
                end
            end

            LOAD: begin
                ld_ready = 1'b1;
                // Loader release wins over a byte offered in the same cycle.
                if (!load_en) begin
                    state_next    = IDLE;
                    byte_cnt_next = '0;
                    if (byte_cnt == '0) begin
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (ld_valid) begin
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        if (byte_cnt == 2'(i)) begin
                            word_next[8*i +: 8] = ld_byte;
                        end
                    end
                    byte_cnt_next = byte_cnt + 2'd1;
                    if (byte_cnt == 2'(BYTES - 1)) begin
                        state_next = WRITE;
                    end
                end
            end

            WRITE: begin
                mem_we        = 1'b1;
                byte_cnt_next = '0;
                if (load_count < COUNT_MAX) begin
                    count_next = load_count + COUNT_ONE;
                end
                // Pointer parks on the last address instead of wrapping.
                if (wr_ptr == LAST_ADDR) begin
                    state_next = FULL;
                end else begin
                    wr_ptr_next = wr_ptr + PTR_ONE;
                    if (load_en) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            FULL: begin
                if (ld_valid) begin
                    err_next = 1'b1;
                end
                if (!load_en) begin
                    state_next = IDLE;
                    done_next  = !(load_err || ld_valid);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
